kypd_emulator: RTL and testbench



---
 rtl/kypd_pkg.sv | 55 +++++
 rtl/kypd_bounce_gen.sv | 66 ++++++
 rtl/kypd_emulator.sv | 189 ++++++++++++++++++
 tb/tb_kypd_emulator.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kypd_pkg.sv
// kypd_pkg: definitions shared by both ends of the 4x4 PmodKYPD scan link.
// The keypad emulator and the scanner-side decoder both import this package,
// so there is a single key map.
//   state_t   : emulator FSM encoding (IDLE, PRESS, RELEASE)
//   key_pos_t : (column, row) position of a key on the 4x4 matrix
//   ROW_IDLE  : value of the active-low row bus when no switch is closed
//   key_pos() : hex key code -> (column, row)
//   max_int() : elaboration-time helper for sizing counters
package kypd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] col;
    logic [1:0] row;
  } key_pos_t;

  localparam logic [3:0] ROW_IDLE = 4'hF;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Column c drives Col[3-c], row r answers on Row[3-r].
  //   c0: 1 4 7 0   c1: 2 5 8 F   c2: 3 6 9 E   c3: A B C D   (r0..r3)
  function automatic key_pos_t key_pos(input logic [3:0] code);
    key_pos_t p;
    p = '0;
    case (code)
      4'h1: p = '{col: 2'd0, row: 2'd0};
      4'h4: p = '{col: 2'd0, row: 2'd1};
      4'h7: p = '{col: 2'd0, row: 2'd2};
      4'h0: p = '{col: 2'd0, row: 2'd3};
      4'h2: p = '{col: 2'd1, row: 2'd0};
      4'h5: p = '{col: 2'd1, row: 2'd1};
      4'h8: p = '{col: 2'd1, row: 2'd2};
      4'hF: p = '{col: 2'd1, row: 2'd3};
      4'h3: p = '{col: 2'd2, row: 2'd0};
      4'h6: p = '{col: 2'd2, row: 2'd1};
      4'h9: p = '{col: 2'd2, row: 2'd2};
      4'hE: p = '{col: 2'd2, row: 2'd3};
      4'hA: p = '{col: 2'd3, row: 2'd0};
      4'hB: p = '{col: 2'd3, row: 2'd1};
      4'hC: p = '{col: 2'd3, row: 2'd2};
      4'hD: p = '{col: 2'd3, row: 2'd3};
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/kypd_bounce_gen.sv
// kypd_bounce_gen: contact-bounce shaper for the keypad emulator.
// On a phase start the effective contact jumps to the new nominal level, then
// for BOUNCE_CYCLES cycles it toggles every BOUNCE_TOGGLE cycles; after the
// window it settles on the nominal level.
// Only elaborated when KYPD_EMU_BOUNCE_EN is defined in the top level.
// Ports:
//   clk       : system clock
//   sys_rst_n : asynchronous active-low reset
//   start     : one-cycle pulse, a new press/release phase begins this edge
//   level     : nominal contact level of the phase that is starting
//   contact   : effective (bouncing) contact, registered
module kypd_bounce_gen #(
  parameter int BOUNCE_CYCLES = 4096,
  parameter int BOUNCE_TOGGLE = 256
) (
  input  logic clk,
  input  logic sys_rst_n,
  input  logic start,
  input  logic level,
  output logic contact
);

  localparam int WIN_W = $clog2(BOUNCE_CYCLES + 1);
  localparam int TOG_W = $clog2(BOUNCE_TOGGLE + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BOUNCE_CYCLES - 1);
  localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(BOUNCE_TOGGLE - 1);

  logic             active_q;
  logic             level_q;
  logic             contact_q;
  logic [WIN_W-1:0] win_q;
  logic [TOG_W-1:0] tog_q;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      active_q  <= 1'b0;
      level_q   <= 1'b0;
      contact_q <= 1'b0;
      win_q     <= '0;
      tog_q     <= '0;
    end else if (start) begin
      // The new level shows on the very first cycle of the phase.
      active_q  <= 1'b1;
      level_q   <= level;
      contact_q <= level;
      win_q     <= '0;
      tog_q     <= '0;
    end else if (active_q) begin
      if (win_q == WIN_LAST) begin
        active_q  <= 1'b0;
        contact_q <= level_q;
      end else begin
        win_q <= win_q + 1'b1;
        if (tog_q == TOG_LAST) begin
          tog_q     <= '0;
          contact_q <= ~contact_q;
        end else begin
          tog_q <= tog_q + 1'b1;
        end
      end
    end
  end

  assign contact = contact_q;

endmodule

// File: rtl/kypd_emulator.sv
// kypd_emulator: keypad-side emulator for the 4x4 PmodKYPD scan interface.
// Accepts a hex key over valid/ready, closes that switch for HOLD_CYCLES,
// then keeps it open for at least RELEASE_CYCLES before taking the next key.
// While the switch is closed, the key's row line is pulled low (registered,
// one cycle after sampling) whenever the scanner drives its column low.
// Optional feature: define KYPD_EMU_BOUNCE_EN to add contact bounce at the
// start of each press and release phase (kypd_bounce_gen).
// Ports:
//   clk       : system clock (100 MHz)
//   sys_rst_n : asynchronous active-low reset
//   key_valid : key request present
//   key_code  : hex key 0x0-0xF
//   key_ready : emulator idle, request accepted on this edge if key_valid
//   Col       : scanner column drive, active-low
//   Row       : emulated row lines, active-low, idle 4'hF
//   pressed   : effective contact state, 1 = switch closed
module kypd_emulator
  import kypd_pkg::*;
#(
  parameter int HOLD_CYCLES    = 100000,
  parameter int RELEASE_CYCLES = 100000
`ifdef KYPD_EMU_BOUNCE_EN
  ,
  parameter int BOUNCE_CYCLES  = 4096,
  parameter int BOUNCE_TOGGLE  = 256
`endif
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic [3:0] Col,
  output logic [3:0] Row,
  output logic       pressed
);

`ifdef KYPD_EMU_BOUNCE_EN
  localparam int CNT_MAX = max_int(max_int(HOLD_CYCLES, RELEASE_CYCLES), BOUNCE_CYCLES);
`else
  localparam int CNT_MAX = max_int(HOLD_CYCLES, RELEASE_CYCLES);
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_CYCLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       key_q;
  logic             contact_q;
  logic             contact_d;
  logic             contact_eff;
  logic [3:0]       row_q;
  logic [3:0]       row_d;
  key_pos_t         key_loc;

  logic hold_done;
  logic rel_done;
  logic key_load;
  logic phase_start;
  logic cnt_clr;
  logic cnt_run;

  // Phase ends on the edge where the counter has seen N-1, so each phase
  // lasts exactly N cycles counted from its entry edge.
  assign hold_done = (state_q == ST_PRESS)   && (cnt_q == HOLD_LAST);
  assign rel_done  = (state_q == ST_RELEASE) && (cnt_q == REL_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking assignment so every register
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: default assignment first so no path leaves state_d unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (key_valid) state_d = ST_PRESS;
      ST_PRESS:   if (hold_done) state_d = ST_RELEASE;
      ST_RELEASE: if (rel_done)  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    key_ready   = 1'b0;
    key_load    = 1'b0;
    phase_start = 1'b0;
    cnt_clr     = 1'b0;
    cnt_run     = 1'b0;
    contact_d   = contact_q;
    case (state_q)
      ST_IDLE: begin
        key_ready = 1'b1;
        cnt_clr   = 1'b1;
        if (key_valid) begin
          key_load    = 1'b1;
          phase_start = 1'b1;
          contact_d   = 1'b1;
        end
      end
      ST_PRESS: begin
        cnt_run = 1'b1;
        if (hold_done) begin
          cnt_clr     = 1'b1;
          phase_start = 1'b1;
          contact_d   = 1'b0;
        end
      end
      ST_RELEASE: begin
        cnt_run = 1'b1;
        cnt_clr = rel_done;
      end
      default: begin
        cnt_clr   = 1'b1;
        contact_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: phase counter, latched key, nominal contact
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q     <= '0;
      key_q     <= '0;
      contact_q <= 1'b0;
    end else begin
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_run) cnt_q <= cnt_q + 1'b1;
      // Only loaded on acceptance, so key_code may wander at any other time.
      if (key_load) key_q <= key_code;
      contact_q <= contact_d;
    end
  end

`ifdef KYPD_EMU_BOUNCE_EN
  kypd_bounce_gen #(
    .BOUNCE_CYCLES (BOUNCE_CYCLES),
    .BOUNCE_TOGGLE (BOUNCE_TOGGLE)
  ) u_bounce (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .start     (phase_start),
    .level     (contact_d),
    .contact   (contact_eff)
  );
`else
  // Without bounce the effective contact is the nominal one; phase_start
  // only matters to the bounce generator.
  assign contact_eff = contact_q;
  logic unused_phase_start;
  assign unused_phase_start = phase_start;
`endif

  // ---------------------------------------------------------------------------
  // Row drive: pull the key's row while closed and its column is scanned.
  // Any other low columns are irrelevant; only the latched key's column counts.
  // ---------------------------------------------------------------------------
  assign key_loc = key_pos(key_q);

  always_comb begin
    row_d = ROW_IDLE;
    if (contact_eff && !Col[2'd3 - key_loc.col]) row_d[2'd3 - key_loc.row] = 1'b0;
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) row_q <= ROW_IDLE;
    else            row_q <= row_d;
  end

  assign Row     = row_q;
  assign pressed = contact_eff;

endmodule

// File: tb/tb_kypd_emulator.sv
// Self-checking bench for kypd_emulator with HOLD_CYCLES=8, RELEASE_CYCLES=4.
// Expected (Row, pressed, key_ready) per edge come from an independent key
// table and the phase timing of an accept on edge N; they are queued when the
// stimulus is driven and compared after the edge.
module tb_kypd_emulator;

  localparam int HOLD = 8;
  localparam int REL  = 4;
  localparam int LAST = HOLD + REL;   // edge offset where key_ready returns

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] Col;
  logic [3:0] Row;
  logic       pressed;

  kypd_emulator #(
    .HOLD_CYCLES    (HOLD),
    .RELEASE_CYCLES (REL)
  ) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .Col       (Col),
    .Row       (Row),
    .pressed   (pressed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] row;
    logic       pressed;
    logic       ready;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // kmap[c][r] = key at column c, row r.
  logic [3:0] kmap [4][4] = '{
    '{4'h1, 4'h4, 4'h7, 4'h0},
    '{4'h2, 4'h5, 4'h8, 4'hF},
    '{4'h3, 4'h6, 4'h9, 4'hE},
    '{4'hA, 4'hB, 4'hC, 4'hD}
  };

  function automatic logic [3:0] row_model(input logic [3:0] code, input logic [3:0] col,
                                           input logic contact);
    logic [3:0] r;
    r = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++)
        if (kmap[c][k] == code && contact && !col[3-c]) r[3-k] = 1'b0;
    return r;
  endfunction

  // Outputs just after edge N+i, where the key was accepted on edge N and
  // col is the column value sampled on that edge.
  function automatic obs_t exp_cycle(input logic [3:0] code, input int i, input logic [3:0] col);
    obs_t o;
    o.row     = row_model(code, col, (i >= 1) && (i <= HOLD));
    o.pressed = (i < HOLD);
    o.ready   = (i >= LAST);
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    sys_rst_n = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    Col       = 4'h0;
    #12;
    n_checks++;
    if ({Row, pressed, key_ready} !== {4'hF, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_asserted: got Row=%b pressed=%b ready=%b, want Row=1111 pressed=0 ready=1",
               Row, pressed, key_ready);
    end
    @(negedge clk);
    sys_rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{row: 4'hF, pressed: 1'b0, ready: 1'b1});
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({Row, pressed, key_ready} !== e) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got Row=%b pressed=%b ready=%b, want Row=%b pressed=%b ready=%b",
                 i, Row, pressed, key_ready, e.row, e.pressed, e.ready);
      end
    end
  endtask

  task automatic test_key5_scan();
    obs_t e;
    for (int i = 0; i <= LAST; i++) begin
      if (i == 0) begin
        key_valid = 1'b1; key_code = 4'h5; Col = 4'hF;
      end else begin
        key_valid = 1'b0;
        key_code  = 4'($urandom_range(0, 15));
        Col       = (i == 2) ? 4'b0111 : 4'b1011;
      end
      exp_q.push_back(exp_cycle(4'h5, i, Col));
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({Row, pressed, key_ready} !== e) begin
        n_fail++;
        $display("FAIL key5_scan[%0d]: got Row=%b pressed=%b ready=%b, want Row=%b pressed=%b ready=%b",
                 i, Row, pressed, key_ready, e.row, e.pressed, e.ready);
      end
    end
  endtask

  // Key D with column 0 held low; key 1 is requested continuously while busy.
  task automatic test_key_d_timing();
    obs_t e;
    int   low_cnt;
    low_cnt = 0;
    Col = 4'b1110;
    for (int i = 0; i <= LAST; i++) begin
      key_valid = 1'b1;
      key_code  = (i == 0) ? 4'hD : 4'h1;
      exp_q.push_back(exp_cycle(4'hD, i, Col));
      tick();
      if (Row == 4'b1110) low_cnt++;
      e = exp_q.pop_front();
      n_checks++;
      if ({Row, pressed, key_ready} !== e) begin
        n_fail++;
        $display("FAIL keyD_timing[%0d]: got Row=%b pressed=%b ready=%b, want Row=%b pressed=%b ready=%b",
                 i, Row, pressed, key_ready, e.row, e.pressed, e.ready);
      end
    end
    n_checks++;
    if (low_cnt !== HOLD) begin
      n_fail++;
      $display("FAIL keyD_row_low_cycles: got %0d, want %0d", low_cnt, HOLD);
    end
  endtask

  // key_valid with code 1 is still held: accepted on the first ready cycle.
  task automatic test_ignored_busy();
    obs_t e;
    Col = 4'b0111;
    for (int i = 0; i <= LAST; i++) begin
      key_valid = (i == 0);
      key_code  = 4'h1;
      exp_q.push_back(exp_cycle(4'h1, i, Col));
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({Row, pressed, key_ready} !== e) begin
        n_fail++;
        $display("FAIL key1_after_busy[%0d]: got Row=%b pressed=%b ready=%b, want Row=%b pressed=%b ready=%b",
                 i, Row, pressed, key_ready, e.row, e.pressed, e.ready);
      end
    end
  endtask

  task automatic test_all_cols_low();
    obs_t e;
    Col = 4'b0000;
    for (int i = 0; i <= LAST; i++) begin
      key_valid = (i == 0);
      key_code  = 4'h0;
      exp_q.push_back(exp_cycle(4'h0, i, Col));
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({Row, pressed, key_ready} !== e) begin
        n_fail++;
        $display("FAIL key0_all_cols[%0d]: got Row=%b pressed=%b ready=%b, want Row=%b pressed=%b ready=%b",
                 i, Row, pressed, key_ready, e.row, e.pressed, e.ready);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    obs_t e;
    Col = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      key_valid = (i == 0);
      key_code  = 4'h7;
      exp_q.push_back(exp_cycle(4'h7, i, Col));
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({Row, pressed, key_ready} !== e) begin
        n_fail++;
        $display("FAIL key7_press[%0d]: got Row=%b pressed=%b ready=%b, want Row=%b pressed=%b ready=%b",
                 i, Row, pressed, key_ready, e.row, e.pressed, e.ready);
      end
    end
    // Mid-cycle reset: outputs must clear without waiting for a clock edge.
    #2;
    sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({Row, pressed, key_ready} !== {4'hF, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset: got Row=%b pressed=%b ready=%b, want Row=1111 pressed=0 ready=1",
               Row, pressed, key_ready);
    end
    @(negedge clk);
    sys_rst_n = 1'b1;
    #1;
    // Latched key 7 must be gone: column 0 still scanned, nothing pulled.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{row: 4'hF, pressed: 1'b0, ready: 1'b1});
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({Row, pressed, key_ready} !== e) begin
        n_fail++;
        $display("FAIL post_reset_idle[%0d]: got Row=%b pressed=%b ready=%b, want Row=%b pressed=%b ready=%b",
                 i, Row, pressed, key_ready, e.row, e.pressed, e.ready);
      end
    end
    // Recovery with a fresh key: 9 is column 2, row 2.
    Col = 4'b1101;
    for (int i = 0; i <= LAST; i++) begin
      key_valid = (i == 0);
      key_code  = 4'h9;
      exp_q.push_back(exp_cycle(4'h9, i, Col));
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({Row, pressed, key_ready} !== e) begin
        n_fail++;
        $display("FAIL key9_recover[%0d]: got Row=%b pressed=%b ready=%b, want Row=%b pressed=%b ready=%b",
                 i, Row, pressed, key_ready, e.row, e.pressed, e.ready);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_key5_scan();
    test_key_d_timing();
    test_ignored_busy();
    test_all_cols_low();
    test_reset_mid_press();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
